memory_unit: RTL and testbench

//  Core-side memory access unit sitting between the microcoded control FSM and the system bus.

---
 rtl/memory_unit.sv | 191 +++++++++++++++++++
 tb/tb_memory_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// Core-side memory access unit: one word-aligned bus transaction per held request, with lane steering and load extension.
// Optional misalignment trap enabled by defining MEMORY_UNIT__MISALIGN_TRAP_EN.
module memory_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_sized,
  input  logic [2:0]            mem_f3,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_complete,
  output logic                  mem_misaligned,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] busAddr_q, busAddr_d;
  logic                  busWe_q, busWe_d;
  logic [3:0]            busBe_q, busBe_d;
  logic [DATA_WIDTH-1:0] busWdata_q, busWdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            off_q, off_d;
  logic                  isByte_q, isByte_d;
  logic                  isHalf_q, isHalf_d;
  logic                  isUnsigned_q, isUnsigned_d;

  logic                  reqIsByte, reqIsHalf;
  logic [1:0]            reqOff;
  logic [3:0]            reqBe;
  logic [DATA_WIDTH-1:0] reqWdata;
  logic [DATA_WIDTH-1:0] shiftedRdata;
  logic [DATA_WIDTH-1:0] loadData;

  // Request decode; undefined f3 codes and unsized fetches fall through to a full word.
  always_comb begin
    reqIsByte = mem_sized && (mem_f3[1:0] == 2'b00);
    reqIsHalf = mem_sized && (mem_f3[1:0] == 2'b01);
    if (reqIsByte) begin
      reqOff   = mem_addr[1:0];
      reqBe    = 4'b0001 << mem_addr[1:0];
      reqWdata = {4{mem_wdata[7:0]}};
    end else if (reqIsHalf) begin
      reqOff   = {mem_addr[1], 1'b0};
      reqBe    = 4'b0011 << {mem_addr[1], 1'b0};
      reqWdata = {2{mem_wdata[15:0]}};
    end else begin
      reqOff   = 2'b00;
      reqBe    = 4'b1111;
      reqWdata = mem_wdata;
    end
  end

  always_comb begin
    shiftedRdata = bus_rdata >> {off_q, 3'b000};
    if (isByte_q) begin
      loadData = {{(DATA_WIDTH-8){~isUnsigned_q & shiftedRdata[7]}}, shiftedRdata[7:0]};
    end else if (isHalf_q) begin
      loadData = {{(DATA_WIDTH-16){~isUnsigned_q & shiftedRdata[15]}}, shiftedRdata[15:0]};
    end else begin
      loadData = shiftedRdata;
    end
  end

`ifdef MEMORY_UNIT__MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  logic reqMisaligned;

  always_comb begin
    reqMisaligned = (reqIsHalf && mem_addr[0]) ||
                    (!reqIsByte && !reqIsHalf && (mem_addr[1:0] != 2'b00));
  end
`endif

  // Next-state logic; bus fields are latched once in IDLE so they stay stable while waiting for ack.
  always_comb begin
    state_d      = state_q;
    busAddr_d    = busAddr_q;
    busWe_d      = busWe_q;
    busBe_d      = busBe_q;
    busWdata_d   = busWdata_q;
    rdata_d      = rdata_q;
    off_d        = off_q;
    isByte_d     = isByte_q;
    isHalf_d     = isHalf_q;
    isUnsigned_d = isUnsigned_q;
`ifdef MEMORY_UNIT__MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
`ifdef MEMORY_UNIT__MISALIGN_TRAP_EN
          if (reqMisaligned) begin
            state_d      = DONE;
            misaligned_d = 1'b1;
          end else begin
`endif
            state_d      = REQ;
            busAddr_d    = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
            busWe_d      = mem_write;
            busBe_d      = mem_write ? reqBe : 4'b1111;
            busWdata_d   = reqWdata;
            off_d        = reqOff;
            isByte_d     = reqIsByte;
            isHalf_d     = reqIsHalf;
            isUnsigned_d = mem_f3[2];
`ifdef MEMORY_UNIT__MISALIGN_TRAP_EN
          end
`endif
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = DONE;
          if (!busWe_q) begin
            rdata_d = loadData;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MEMORY_UNIT__MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busAddr_q    <= '0;
      busWe_q      <= 1'b0;
      busBe_q      <= 4'b0000;
      busWdata_q   <= '0;
      rdata_q      <= '0;
      off_q        <= 2'b00;
      isByte_q     <= 1'b0;
      isHalf_q     <= 1'b0;
      isUnsigned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busAddr_q    <= busAddr_d;
      busWe_q      <= busWe_d;
      busBe_q      <= busBe_d;
      busWdata_q   <= busWdata_d;
      rdata_q      <= rdata_d;
      off_q        <= off_d;
      isByte_q     <= isByte_d;
      isHalf_q     <= isHalf_d;
      isUnsigned_q <= isUnsigned_d;
    end
  end

`ifdef MEMORY_UNIT__MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign mem_misaligned = misaligned_q;
`else
  assign mem_misaligned = 1'b0;
`endif

  assign bus_req      = (state_q == REQ);
  assign mem_complete = (state_q == DONE);
  assign bus_we       = busWe_q;
  assign bus_addr     = busAddr_q;
  assign bus_be       = busBe_q;
  assign bus_wdata    = busWdata_q;
  assign mem_rdata    = rdata_q;

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: stimulus pushes expected bus transactions and completions,
// a bus responder and a completion monitor pop and compare independently.
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_sized = 1'b0;
  logic [2:0]  mem_f3 = 3'b000;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_complete;
  logic        mem_misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  memory_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_sized(mem_sized), .mem_f3(mem_f3), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_complete(mem_complete), .mem_misaligned(mem_misaligned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chkWdata;
    logic [31:0] rdata;
    int          delay;
    int          reqCycle;
  } busItem_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          cycle;
  } cmpItem_t;

  busItem_t    busQ[$];
  cmpItem_t    cmpQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  int          lastDone = -10;
  logic [31:0] lastRdata = '0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Bus responder: checks the presented transaction every waiting cycle, acks after the item's delay.
  initial begin
    int waitCnt;
    busItem_t it;
    waitCnt = 0;
    forever begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 32'hDEAD_DEAD;
      if (rst) begin
        waitCnt = 0;
      end else if (bus_req) begin
        if (busQ.size() == 0) begin
          checkOutput("busReqUnexpected", {31'b0, bus_req}, 32'h0);
        end else begin
          it = busQ[0];
          if (waitCnt == 0) checkOutput("busReqCycle", cycleCnt, it.reqCycle);
          checkOutput("busAddr", bus_addr, it.addr);
          checkOutput("busWe", {31'b0, bus_we}, {31'b0, it.we});
          checkOutput("busBe", {28'b0, bus_be}, {28'b0, it.be});
          if (it.chkWdata) checkOutput("busWdata", bus_wdata, it.wdata);
          if (waitCnt == it.delay) begin
            bus_ack   = 1'b1;
            bus_rdata = it.rdata;
            void'(busQ.pop_front());
            waitCnt = 0;
          end else begin
            waitCnt++;
          end
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    cmpItem_t c;
    forever begin
      @(negedge clk);
      if (!rst && mem_complete) begin
        if (cmpQ.size() == 0) begin
          checkOutput("completeUnexpected", {31'b0, mem_complete}, 32'h0);
        end else begin
          c = cmpQ.pop_front();
          checkOutput("memRdata", mem_rdata, c.rdata);
          checkOutput("memMisaligned", {31'b0, mem_misaligned}, {31'b0, c.mis});
          checkOutput("completeCycle", cycleCnt, c.cycle);
        end
      end
    end
  end

  // Issues one request at a negedge and holds it until mem_complete.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic sized, input logic [2:0] f3, input logic [31:0] wdata,
                               input logic [31:0] brdata, input int delay,
                               input logic [31:0] expBa, input logic [3:0] expBe,
                               input logic [31:0] expBw, input logic [31:0] expRd,
                               input logic expMis);
    busItem_t b;
    cmpItem_t c;
    int start;
    int n;
    start = (cycleCnt == lastDone) ? cycleCnt + 1 : cycleCnt;
    if (expMis) begin
      c.rdata = lastRdata;
      c.mis   = 1'b1;
      c.cycle = start + 1;
    end else begin
      b.addr = expBa; b.we = wr; b.be = expBe; b.wdata = expBw; b.chkWdata = wr;
      b.rdata = brdata; b.delay = delay; b.reqCycle = start + 1;
      busQ.push_back(b);
      if (!wr) lastRdata = expRd;
      c.rdata = lastRdata;
      c.mis   = 1'b0;
      c.cycle = start + 2 + delay;
    end
    cmpQ.push_back(c);
    mem_read = rd; mem_write = wr; mem_addr = addr;
    mem_sized = sized; mem_f3 = f3; mem_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_complete && n < 60);
    if (!mem_complete) checkOutput("completeTimeout", {31'b0, mem_complete}, 32'h1);
    lastDone = cycleCnt;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "BusReq"}, {31'b0, bus_req}, 32'h0);
    checkOutput({tag, "BusWe"}, {31'b0, bus_we}, 32'h0);
    checkOutput({tag, "BusAddr"}, bus_addr, 32'h0);
    checkOutput({tag, "BusBe"}, {28'b0, bus_be}, 32'h0);
    checkOutput({tag, "BusWdata"}, bus_wdata, 32'h0);
    checkOutput({tag, "MemRdata"}, mem_rdata, 32'h0);
    checkOutput({tag, "Complete"}, {31'b0, mem_complete}, 32'h0);
    checkOutput({tag, "Misaligned"}, {31'b0, mem_misaligned}, 32'h0);
  endtask

  initial begin
    busItem_t b;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fetch, then byte loads signed/unsigned.
    applyStimulus(1, 0, 32'h100, 0, 3'b000, 32'h0, 32'h0050_0093, 0, 32'h100, 4'hF, 32'h0, 32'h0050_0093, 0);
    @(negedge clk);
    applyStimulus(1, 0, 32'h203, 1, 3'b000, 32'h0, 32'h80FF_1234, 0, 32'h200, 4'hF, 32'h0, 32'hFFFF_FF80, 0);
    applyStimulus(1, 0, 32'h203, 1, 3'b100, 32'h0, 32'h80FF_1234, 2, 32'h200, 4'hF, 32'h0, 32'h0000_0080, 0);
    // Stores leave mem_rdata unchanged; write wins when both requests are high.
    applyStimulus(0, 1, 32'h302, 1, 3'b001, 32'hDEAD_BEEF, 32'h0, 1, 32'h300, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0);
    applyStimulus(0, 1, 32'h101, 1, 3'b000, 32'h1234_5678, 32'h0, 0, 32'h100, 4'b0010, 32'h7878_7878, 32'h0, 0);
    applyStimulus(1, 1, 32'h044, 1, 3'b010, 32'hA5A5_0F0F, 32'h0, 0, 32'h044, 4'b1111, 32'hA5A5_0F0F, 32'h0, 0);
    // Halfword loads and undefined f3 codes.
    applyStimulus(1, 0, 32'h202, 1, 3'b001, 32'h0, 32'h80FF_1234, 0, 32'h200, 4'hF, 32'h0, 32'hFFFF_80FF, 0);
    applyStimulus(1, 0, 32'h200, 1, 3'b101, 32'h0, 32'h80FF_1234, 0, 32'h200, 4'hF, 32'h0, 32'h0000_1234, 0);
    applyStimulus(1, 0, 32'h200, 1, 3'b001, 32'h0, 32'h1234_F00D, 0, 32'h200, 4'hF, 32'h0, 32'hFFFF_F00D, 0);
    applyStimulus(1, 0, 32'h204, 1, 3'b011, 32'h0, 32'hCAFE_BABE, 0, 32'h204, 4'hF, 32'h0, 32'hCAFE_BABE, 0);
    applyStimulus(1, 0, 32'h208, 1, 3'b111, 32'h0, 32'h0BAD_F00D, 0, 32'h208, 4'hF, 32'h0, 32'h0BAD_F00D, 0);
    // Long ack wait followed immediately by a back-to-back request.
    @(negedge clk);
    applyStimulus(1, 0, 32'h500, 1, 3'b010, 32'h0, 32'h1122_3344, 5, 32'h500, 4'hF, 32'h0, 32'h1122_3344, 0);
    applyStimulus(1, 0, 32'h501, 1, 3'b100, 32'h0, 32'hAABB_CCDD, 0, 32'h500, 4'hF, 32'h0, 32'h0000_00CC, 0);

    // Reset in the middle of a bus wait.
    @(negedge clk);
    b.addr = 32'h600; b.we = 1'b0; b.be = 4'hF; b.wdata = 32'h0; b.chkWdata = 1'b0;
    b.rdata = 32'h0; b.delay = 20; b.reqCycle = cycleCnt + 1;
    busQ.push_back(b);
    mem_read = 1'b1; mem_sized = 1'b0; mem_addr = 32'h600;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkAllZero("asyncRst");
    busQ.delete();
    mem_read = 1'b0;
    lastRdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1, 0, 32'h700, 0, 3'b000, 32'h0, 32'h1357_9BDF, 1, 32'h700, 4'hF, 32'h0, 32'h1357_9BDF, 0);

    // Misaligned word load.
    @(negedge clk);
`ifdef MEMORY_UNIT__MISALIGN_TRAP_EN
    applyStimulus(1, 0, 32'h401, 1, 3'b010, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
    applyStimulus(1, 0, 32'h403, 1, 3'b001, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
`else
    applyStimulus(1, 0, 32'h401, 1, 3'b010, 32'h0, 32'h5566_7788, 0, 32'h400, 4'hF, 32'h0, 32'h5566_7788, 0);
    applyStimulus(1, 0, 32'h403, 1, 3'b001, 32'h0, 32'h8001_2345, 0, 32'h400, 4'hF, 32'h0, 32'hFFFF_8001, 0);
`endif

    repeat (5) @(negedge clk);
    checkOutput("busQueueDrained", busQ.size(), 32'h0);
    checkOutput("cmpQueueDrained", cmpQ.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion before 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
